// File: rtl/axi_config_rw.sv
// AXI4 slave to single-beat register-file strobe bridge.
// Write and read engines run independently; each AXI burst is broken into
// one wr/rd strobe per beat with the beat address generated locally.
module axi_config_rw #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH     = 8,
    parameter int unsigned AWUSER_WIDTH = 1,
    parameter int unsigned WUSER_WIDTH  = 1,
    parameter int unsigned ARUSER_WIDTH = 1,
    parameter int unsigned BUSER_WIDTH  = 1,
    parameter int unsigned RUSER_WIDTH  = 1,
    parameter bit          REG_DATA     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    // AW channel
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic [3:0]              s_axi_awregion,
    input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    // W channel
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic [WUSER_WIDTH-1:0]  s_axi_wuser,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    // B channel
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic [BUSER_WIDTH-1:0]  s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    // AR channel
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic [3:0]              s_axi_arregion,
    input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    // R channel
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    // Register-file side
    output logic                    wr,
    output logic [ADDR_WIDTH-1:0]   waddr,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [STRB_WIDTH-1:0]   wstrb,
    output logic                    rd,
    output logic [ADDR_WIDTH-1:0]   raddr,
    output logic [ADDR_WIDTH-1:0]   raddr_next,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    rvalid
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_t;

    // Address of the beat after addr for the given AXI burst parameters.
    function automatic logic [ADDR_WIDTH-1:0] beat_next(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] result;
        inc  = ADDR_WIDTH'(1) << size;
        mask = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * inc - ADDR_WIDTH'(1);
        case (burst)
            2'd0:    result = addr;
            2'd2:    result = (addr & ~mask) | ((addr + inc) & mask);
            default: result = addr + inc;
        endcase
        return result;
    endfunction

    w_state_t              w_state, w_state_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;

    r_state_t              r_state, r_state_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_count;
    logic                  r_last;
    logic                  r_hs;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                             s_axi_awregion, s_axi_awuser, s_axi_wuser,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                             s_axi_arregion, s_axi_aruser};

    assign s_axi_bid   = w_id;
    assign s_axi_bresp = 2'b00;
    assign s_axi_buser = '0;
    assign s_axi_rid   = r_id;
    assign s_axi_rresp = 2'b00;
    assign s_axi_ruser = '0;
    assign r_last      = (r_count == r_len);
    assign raddr_next  = beat_next(raddr, r_len, r_size, r_burst);

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_next;
    end

    // Write FSM next state; the burst ends on wlast regardless of awlen
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (s_axi_awvalid)                w_state_next = W_DATA;
            W_DATA:  if (s_axi_wvalid && s_axi_wlast)  w_state_next = W_RESP;
            W_RESP:  if (s_axi_bready)                 w_state_next = W_IDLE;
            default:                                   w_state_next = W_IDLE;
        endcase
    end

    // Write FSM handshake outputs
    always_comb begin
        s_axi_awready = (w_state == W_IDLE);
        s_axi_wready  = (w_state == W_DATA);
        s_axi_bvalid  = (w_state == W_RESP);
    end

    // Write datapath: burst context and registered one-cycle write strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            wr      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else begin
            wr <= 1'b0;
            if (s_axi_awvalid && s_axi_awready) begin
                w_id    <= s_axi_awid;
                w_addr  <= s_axi_awaddr;
                w_len   <= s_axi_awlen;
                w_size  <= s_axi_awsize;
                w_burst <= s_axi_awburst;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                wr     <= 1'b1;
                waddr  <= w_addr;
                wdata  <= s_axi_wdata;
                wstrb  <= s_axi_wstrb;
                w_addr <= beat_next(w_addr, w_len, w_size, w_burst);
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_next;
    end

    // Read FSM next state; without REG_DATA the R handshake happens in WAIT
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (s_axi_arvalid) r_state_next = R_ISSUE;
            R_ISSUE: r_state_next = R_WAIT;
            R_WAIT: begin
                if (REG_DATA) begin
                    if (rvalid) r_state_next = R_RESP;
                end else if (rvalid && s_axi_rready) begin
                    r_state_next = r_last ? R_IDLE : R_ISSUE;
                end
            end
            R_RESP:  if (s_axi_rready) r_state_next = r_last ? R_IDLE : R_ISSUE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read FSM outputs: strobe, R channel valid/data selection
    always_comb begin
        s_axi_arready = (r_state == R_IDLE);
        rd            = (r_state == R_ISSUE);
        if (REG_DATA) begin
            s_axi_rvalid = (r_state == R_RESP);
            s_axi_rdata  = rdata_q;
        end else begin
            s_axi_rvalid = (r_state == R_WAIT) && rvalid;
            s_axi_rdata  = rdata;
        end
        s_axi_rlast = s_axi_rvalid && r_last;
        r_hs        = s_axi_rvalid && s_axi_rready;
    end

    // Read datapath: burst context, beat counter/address, captured data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id    <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_count <= '0;
            raddr   <= '0;
            rdata_q <= '0;
        end else begin
            if (s_axi_arvalid && s_axi_arready) begin
                r_id    <= s_axi_arid;
                r_len   <= s_axi_arlen;
                r_size  <= s_axi_arsize;
                r_burst <= s_axi_arburst;
                r_count <= '0;
                raddr   <= s_axi_araddr;
            end
            if (r_state == R_WAIT && rvalid) rdata_q <= rdata;
            if (r_hs && !r_last) begin
                r_count <= r_count + 8'd1;
                raddr   <= raddr_next;
            end
        end
    end

endmodule

// File: tb/tb_axi_config_rw.sv
// Directed self-checking bench for axi_config_rw (REG_DATA=1).
// The register-file model returns rdata = beat address one cycle after rd,
// and drives junk data whenever it has nothing to return.
module tb_axi_config_rw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axi_awid = '0;
    logic [31:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = '0;
    logic [1:0]  s_axi_awburst = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [7:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic [0:0]  s_axi_buser;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [7:0]  s_axi_arid = '0;
    logic [31:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = '0;
    logic [1:0]  s_axi_arburst = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [7:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic [0:0]  s_axi_ruser;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rd;
    logic [31:0] raddr;
    logic [31:0] raddr_next;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0;

    int checks = 0;
    int errors = 0;

    axi_config_rw #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .REG_DATA(1'b1)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0), .s_axi_awregion(4'd0),
        .s_axi_awuser(1'b0), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wuser(1'b0), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0), .s_axi_arregion(4'd0),
        .s_axi_aruser(1'b0), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .wr(wr), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .rd(rd), .raddr(raddr), .raddr_next(raddr_next), .rdata(rdata), .rvalid(rvalid)
    );

    always #5 clk = ~clk;

    // Register-file model: one-cycle latency, echoes the strobed address
    initial begin
        logic        pend;
        logic [31:0] pend_data;
        pend = 1'b0;
        pend_data = '0;
        forever begin
            @(posedge clk);
            #1;
            rvalid = pend;
            rdata  = pend ? pend_data : 32'hBAD0_BAD0;
            pend      = rd;
            pend_data = raddr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if ({wr, rd, s_axi_bvalid, s_axi_rvalid, s_axi_rlast} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 00000", {wr, rd, s_axi_bvalid, s_axi_rvalid, s_axi_rlast}); end
        checks++; if (waddr !== 32'h0 || raddr !== 32'h0) begin errors++; $display("FAIL reset_addr: waddr=%h raddr=%h expected 0/0", waddr, raddr); end
        checks++; if ({s_axi_bresp, s_axi_rresp, s_axi_buser, s_axi_ruser} !== 6'b0) begin errors++; $display("FAIL reset_resp: got %b expected 0", {s_axi_bresp, s_axi_rresp, s_axi_buser, s_axi_ruser}); end
        checks++; if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1 || s_axi_wready !== 1'b0) begin errors++; $display("FAIL reset_ready: aw=%b ar=%b w=%b expected 1 1 0", s_axi_awready, s_axi_arready, s_axi_wready); end
        tick();
        checks++; if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: aw=%b ar=%b expected 1 1", s_axi_awready, s_axi_arready); end
    endtask

    task automatic test_single_write();
        s_axi_awid = 8'h5A; s_axi_awaddr = 32'h10; s_axi_awlen = 8'd0;
        s_axi_awsize = 3'd2; s_axi_awburst = 2'd1; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL single_w_in_idle: wr=%b expected 0", wr); end
        checks++; if (s_axi_wready !== 1'b1 || s_axi_awready !== 1'b0) begin errors++; $display("FAIL single_ready: wready=%b awready=%b expected 1 0", s_axi_wready, s_axi_awready); end
        tick();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        checks++; if (wr !== 1'b1 || waddr !== 32'h10) begin errors++; $display("FAIL single_wr: wr=%b waddr=%h expected 1 00000010", wr, waddr); end
        checks++; if (wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin errors++; $display("FAIL single_wdata: wdata=%h wstrb=%h expected deadbeef f", wdata, wstrb); end
        checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bid !== 8'h5A || s_axi_bresp !== 2'b00) begin errors++; $display("FAIL single_b: bvalid=%b bid=%h bresp=%b expected 1 5a 00", s_axi_bvalid, s_axi_bid, s_axi_bresp); end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        checks++; if (wr !== 1'b0 || s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin errors++; $display("FAIL single_done: wr=%b bvalid=%b awready=%b expected 0 0 1", wr, s_axi_bvalid, s_axi_awready); end
    endtask

    task automatic test_incr_burst();
        logic [31:0] exp_a [4];
        exp_a[0] = 32'h100; exp_a[1] = 32'h104; exp_a[2] = 32'h108; exp_a[3] = 32'h10C;
        s_axi_awid = 8'h21; s_axi_awaddr = 32'h100; s_axi_awlen = 8'd3;
        s_axi_awsize = 3'd2; s_axi_awburst = 2'd1; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_axi_wdata  = 32'hA000_0000 + 32'(i);
            s_axi_wstrb  = 4'b0001 << i;
            s_axi_wlast  = (i == 3);
            s_axi_wvalid = 1'b1;
            tick();
            checks++; if (wr !== 1'b1 || waddr !== exp_a[i]) begin errors++; $display("FAIL incr_beat%0d_addr: wr=%b waddr=%h expected 1 %h", i, wr, waddr, exp_a[i]); end
            checks++; if (wdata !== 32'hA000_0000 + 32'(i) || wstrb !== 4'b0001 << i) begin errors++; $display("FAIL incr_beat%0d_data: wdata=%h wstrb=%h", i, wdata, wstrb); end
            checks++; if (s_axi_bvalid !== (i == 3)) begin errors++; $display("FAIL incr_beat%0d_bvalid: bvalid=%b expected %b", i, s_axi_bvalid, (i == 3)); end
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        tick();
        checks++; if (wr !== 1'b0 || s_axi_bvalid !== 1'b1 || s_axi_bid !== 8'h21) begin errors++; $display("FAIL incr_b_hold: wr=%b bvalid=%b bid=%h expected 0 1 21", wr, s_axi_bvalid, s_axi_bid); end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        checks++; if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin errors++; $display("FAIL incr_done: bvalid=%b awready=%b expected 0 1", s_axi_bvalid, s_axi_awready); end
    endtask

    task automatic test_wrap_read();
        logic [31:0] exp_a [4];
        logic [31:0] exp_n [4];
        exp_a[0] = 32'h38; exp_a[1] = 32'h3C; exp_a[2] = 32'h30; exp_a[3] = 32'h34;
        exp_n[0] = 32'h3C; exp_n[1] = 32'h30; exp_n[2] = 32'h34; exp_n[3] = 32'h38;
        s_axi_rready = 1'b1;
        s_axi_arid = 8'h33; s_axi_araddr = 32'h38; s_axi_arlen = 8'd3;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'd2; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd !== 1'b1 || raddr !== exp_a[i] || raddr_next !== exp_n[i]) begin errors++; $display("FAIL wrap_issue%0d: rd=%b raddr=%h next=%h expected 1 %h %h", i, rd, raddr, raddr_next, exp_a[i], exp_n[i]); end
            tick();
            checks++; if (rd !== 1'b0 || s_axi_rvalid !== 1'b0 || raddr_next !== exp_n[i]) begin errors++; $display("FAIL wrap_wait%0d: rd=%b rvalid=%b next=%h expected 0 0 %h", i, rd, s_axi_rvalid, raddr_next, exp_n[i]); end
            tick();
            checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp_a[i] || s_axi_rid !== 8'h33 || s_axi_rresp !== 2'b00) begin errors++; $display("FAIL wrap_r%0d: rvalid=%b rdata=%h rid=%h rresp=%b expected 1 %h 33 00", i, s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rresp, exp_a[i]); end
            checks++; if (s_axi_rlast !== (i == 3)) begin errors++; $display("FAIL wrap_rlast%0d: rlast=%b expected %b", i, s_axi_rlast, (i == 3)); end
            tick();
        end
        checks++; if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0 || rd !== 1'b0) begin errors++; $display("FAIL wrap_done: arready=%b rvalid=%b rd=%b expected 1 0 0", s_axi_arready, s_axi_rvalid, rd); end
    endtask

    task automatic test_read_backpressure();
        s_axi_rready = 1'b0;
        s_axi_arid = 8'h44; s_axi_araddr = 32'h80; s_axi_arlen = 8'd1;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'd1; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        checks++; if (rd !== 1'b1 || raddr !== 32'h80) begin errors++; $display("FAIL bp_issue0: rd=%b raddr=%h expected 1 00000080", rd, raddr); end
        tick();
        tick();
        checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h80 || s_axi_rlast !== 1'b0) begin errors++; $display("FAIL bp_r0: rvalid=%b rdata=%h rlast=%b expected 1 00000080 0", s_axi_rvalid, s_axi_rdata, s_axi_rlast); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h80 || rd !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: rvalid=%b rdata=%h rd=%b expected 1 00000080 0", i, s_axi_rvalid, s_axi_rdata, rd); end
        end
        s_axi_rready = 1'b1;
        tick();
        checks++; if (rd !== 1'b1 || raddr !== 32'h84 || s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL bp_issue1: rd=%b raddr=%h rvalid=%b expected 1 00000084 0", rd, raddr, s_axi_rvalid); end
        tick();
        tick();
        checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h84 || s_axi_rlast !== 1'b1 || s_axi_rid !== 8'h44) begin errors++; $display("FAIL bp_r1: rvalid=%b rdata=%h rlast=%b rid=%h expected 1 00000084 1 44", s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rid); end
        tick();
        checks++; if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL bp_done: arready=%b rvalid=%b expected 1 0", s_axi_arready, s_axi_rvalid); end
    endtask

    task automatic test_fixed_read();
        s_axi_rready = 1'b1;
        s_axi_arid = 8'h07; s_axi_araddr = 32'h20; s_axi_arlen = 8'd2;
        s_axi_arsize = 3'd2; s_axi_arburst = 2'd0; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd !== 1'b1 || raddr !== 32'h20 || raddr_next !== 32'h20) begin errors++; $display("FAIL fixed_issue%0d: rd=%b raddr=%h next=%h expected 1 00000020 00000020", i, rd, raddr, raddr_next); end
            tick();
            tick();
            checks++; if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h20 || s_axi_rlast !== (i == 2)) begin errors++; $display("FAIL fixed_r%0d: rvalid=%b rdata=%h rlast=%b expected 1 00000020 %b", i, s_axi_rvalid, s_axi_rdata, s_axi_rlast, (i == 2)); end
            tick();
        end
        checks++; if (s_axi_arready !== 1'b1 || rd !== 1'b0) begin errors++; $display("FAIL fixed_done: arready=%b rd=%b expected 1 0", s_axi_arready, rd); end
    endtask

    task automatic test_reset_mid_burst();
        s_axi_awid = 8'h11; s_axi_awaddr = 32'h200; s_axi_awlen = 8'd3;
        s_axi_awsize = 3'd2; s_axi_awburst = 2'd1; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wdata = 32'h0000_0001; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
        tick();
        checks++; if (wr !== 1'b1 || waddr !== 32'h200) begin errors++; $display("FAIL midrst_beat0: wr=%b waddr=%h expected 1 00000200", wr, waddr); end
        s_axi_wdata = 32'h0000_0002;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_axi_wvalid = 1'b0;
        checks++; if (wr !== 1'b0 || s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b0 || waddr !== 32'h0) begin errors++; $display("FAIL midrst_cleared: wr=%b bvalid=%b awready=%b wready=%b waddr=%h expected 0 0 1 0 0", wr, s_axi_bvalid, s_axi_awready, s_axi_wready, waddr); end
        tick();
        checks++; if (wr !== 1'b0 || s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin errors++; $display("FAIL midrst_after: wr=%b bvalid=%b awready=%b expected 0 0 1", wr, s_axi_bvalid, s_axi_awready); end
        s_axi_awid = 8'h66; s_axi_awaddr = 32'h44; s_axi_awlen = 8'd0;
        s_axi_awsize = 3'd2; s_axi_awburst = 2'd1; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'h3; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        checks++; if (wr !== 1'b1 || waddr !== 32'h44 || wdata !== 32'h1234_5678 || wstrb !== 4'h3) begin errors++; $display("FAIL midrst_new_wr: wr=%b waddr=%h wdata=%h wstrb=%h expected 1 00000044 12345678 3", wr, waddr, wdata, wstrb); end
        checks++; if (s_axi_bvalid !== 1'b1 || s_axi_bid !== 8'h66) begin errors++; $display("FAIL midrst_new_b: bvalid=%b bid=%h expected 1 66", s_axi_bvalid, s_axi_bid); end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        checks++; if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin errors++; $display("FAIL midrst_new_done: bvalid=%b awready=%b expected 0 1", s_axi_bvalid, s_axi_awready); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_incr_burst();
        test_wrap_read();
        test_read_backpressure();
        test_fixed_read();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
